sensor_frame_tx: RTL and testbench
==================================

SENSOR_FRAME_TX -- requirements
Module: sensor_frame_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of sensor channels (1..16).
REQ-002 SHALL have parameter DATA_W, default 4, bits per channel (1..8).
REQ-003 SHALL have parameter INTERVAL, default 12_000_000, clk cycles between automatic frames (>=2).
REQ-004 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-005 SHALL have parameter CSUM_EN, default 1; 1 appends a checksum byte.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rstn, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ch_data, input, NUM_CH*DATA_W, channel samples; channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 SHALL have port trig, input, 1, request an immediate frame.
REQ-010 SHALL have port tx_ready, input, 1, UART transmitter idle.
REQ-011 SHALL have port tx_start, output, 1, one-cycle byte-start pulse to the UART.
REQ-012 SHALL have port tx_data, output, 8, byte presented to the UART.
REQ-013 SHALL have port busy, output, 1, frame in progress.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse after the last byte completes.

Function
REQ-015 SHALL transmit frames as: HEADER, channel 0 .. channel NUM_CH-1 (each zero-extended to 8 bits), then checksum if CSUM_EN=1.
REQ-016 Checksum SHALL be the 8-bit sum, modulo 256, of HEADER and all channel bytes.
REQ-017 SHALL capture all of ch_data into a snapshot register in the cycle the frame starts; ch_data changes during a frame SHALL NOT affect it.
REQ-018 Interval counter SHALL count 0..INTERVAL-1 continuously, wrap to 0, and issue an auto request on the wrap cycle.
REQ-019 A trig or auto request while idle SHALL start a frame on the next clk edge.
REQ-020 Requests arriving while busy SHALL set a single pending flag; further requests SHALL be merged; the pending frame SHALL start the cycle after frame_done.
REQ-021 Simultaneous trig and auto request SHALL produce exactly one frame.
REQ-022 States SHALL be IDLE, LOAD, ISSUE, WAIT_LOW, WAIT_HIGH, DONE.
REQ-023 IDLE -> LOAD on request; LOAD snapshots data and clears byte index -> ISSUE.
REQ-024 ISSUE SHALL assert tx_start for exactly one cycle only when tx_ready=1, holding tx_data stable from that cycle until the state leaves WAIT_HIGH; then -> WAIT_LOW.
REQ-025 WAIT_LOW -> WAIT_HIGH when tx_ready=0; WAIT_HIGH -> ISSUE (next byte) or DONE (last byte) when tx_ready=1.
REQ-026 DONE SHALL pulse frame_done for one cycle, then go to LOAD if pending, else IDLE.
REQ-027 busy SHALL be 1 in every state except IDLE.
REQ-028 Byte index width SHALL be clog2(NUM_CH+2); frame length SHALL be NUM_CH+1+CSUM_EN bytes.
REQ-029 Checksum accumulator SHALL be 8 bits, cleared in LOAD, updated with each byte when it is issued.

Reset
REQ-030 rstn=0 SHALL force, asynchronously: state IDLE, tx_start 0, tx_data 8'h00, busy 0, frame_done 0, pending 0, interval counter 0, snapshot 0, checksum 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame with no further tx_start; after release the first frame SHALL come from a fresh request.

Structure
REQ-032 State encoding and frame-length/index-width constants SHALL reside in the shared package sensor_frame_pkg.
REQ-033 The interval counter SHALL be a sub-module named interval_tick with parameter INTERVAL and a one-cycle tick output.
REQ-034 The block SHALL connect to the existing uart_tx via tx_start/tx_data/tx_ready without modifying it.

Verification
REQ-035 NUM_CH=2, DATA_W=4, ch_data=8'h3C, trig pulse -> bytes A5, 0C, 03, B4, then frame_done pulse.
REQ-036 CSUM_EN=0, same stimulus -> exactly 3 bytes A5, 0C, 03; no fourth tx_start.
REQ-037 INTERVAL=100, no trig -> frames start at cycles 100, 200, 300 after reset release (+/-1), no overlap.
REQ-038 Three trig pulses during one busy frame -> exactly one extra frame, starting the cycle after frame_done.
REQ-039 ch_data changed 8'h3C -> 8'hFF after header issued -> frame still carries 0C, 03, B4.
REQ-040 rstn asserted while waiting on byte 2 -> tx_start, busy, frame_done 0 immediately; no bytes until next request.

Source files
------------

// File: rtl/sensor_frame_pkg.sv
// Shared definitions for the sensor frame transmitter: FSM encoding and
// frame geometry helpers.
package sensor_frame_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StIssue,
    StWaitLow,
    StWaitHigh,
    StDone
  } state_e;

  // Bytes per frame: header, one per channel, optional checksum.
  function automatic int unsigned frame_len(input int unsigned num_ch,
                                            input int unsigned csum_en);
    return num_ch + 1 + ((csum_en != 0) ? 1 : 0);
  endfunction

  // Byte index width; covers indices 0 .. num_ch+1.
  function automatic int unsigned idx_width(input int unsigned num_ch);
    return $clog2(num_ch + 2);
  endfunction

endpackage

// File: rtl/interval_tick.sv
// Free-running 0..INTERVAL-1 counter with a one-cycle tick on the wrap cycle.
module interval_tick #(
  parameter int unsigned INTERVAL = 12_000_000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick
);

  localparam int unsigned     CntW   = $clog2(INTERVAL);
  localparam logic [CntW-1:0] CntMax = CntW'(INTERVAL - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Tick while the counter sits at its last value, then wrap to zero.
  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  // Counter state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sensor_frame_tx.sv
// Periodic / triggered sensor frame sender feeding a byte-wide UART
// transmitter through a tx_start / tx_data / tx_ready handshake.
module sensor_frame_tx
  import sensor_frame_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned INTERVAL = 12_000_000,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int unsigned CSUM_EN  = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic                     trig,
  input  logic                     tx_ready,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned     FrameLen = frame_len(NUM_CH, CSUM_EN);
  localparam int unsigned     IdxW     = idx_width(NUM_CH);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(FrameLen - 1);

  state_e                   state_q, state_d;
  logic                     pending_q, pending_d;
  logic [NUM_CH*DATA_W-1:0] snap_q, snap_d;
  logic [7:0]               csum_q, csum_d;
  logic [IdxW-1:0]          idx_q, idx_d;
  logic [7:0]               tx_data_q, tx_data_d;
  logic [IdxW-1:0]          idx_nxt;
  logic [7:0]               next_byte;
  logic                     tick;
  logic                     req;

  interval_tick #(
    .INTERVAL(INTERVAL)
  ) u_interval_tick (
    .clk (clk),
    .rstn(rstn),
    .tick(tick)
  );

  assign req     = trig | tick;
  assign idx_nxt = idx_q + IdxW'(1);

  // Byte following the current one: a zero-extended channel, else the checksum.
  always_comb begin
    next_byte = csum_q;
    for (int k = 0; k < NUM_CH; k++) begin
      if (idx_nxt == IdxW'(k + 1)) begin
        next_byte                = '0;
        next_byte[DATA_W-1:0]    = snap_q[k*DATA_W +: DATA_W];
      end
    end
  end

  // Frame sequencing, request merging and byte handshake.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    snap_d    = snap_q;
    csum_d    = csum_q;
    idx_d     = idx_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;

    // Any request seen mid-frame collapses into one pending frame.
    if (req && (state_q != StIdle)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        snap_d    = ch_data;
        idx_d     = '0;
        csum_d    = '0;
        tx_data_d = HEADER;
        state_d   = StIssue;
      end
      StIssue: begin
        if (tx_ready) begin
          tx_start = 1'b1;
          csum_d   = csum_q + tx_data_q;
          state_d  = StWaitLow;
        end
      end
      StWaitLow: begin
        if (!tx_ready) begin
          state_d = StWaitHigh;
        end
      end
      StWaitHigh: begin
        if (tx_ready) begin
          if (idx_q == LastIdx) begin
            state_d = StDone;
          end else begin
            idx_d     = idx_nxt;
            tx_data_d = next_byte;
            state_d   = StIssue;
          end
        end
      end
      StDone: begin
        // A request landing in this very cycle joins the pending frame.
        state_d   = (pending_q || req) ? StLoad : StIdle;
        pending_d = 1'b0;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      pending_q <= 1'b0;
      snap_q    <= '0;
      csum_q    <= '0;
      idx_q     <= '0;
      tx_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      csum_q    <= csum_d;
      idx_q     <= idx_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = (state_q == StDone);

endmodule

// File: tb/tb_sensor_frame_tx.sv
// Scoreboard bench: inst0 default checksum frames, inst1 no checksum,
// inst2 auto frames every 100 cycles.
module tb_sensor_frame_tx;

  logic       clk = 1'b0;
  logic       rstn       [3];
  logic       trig       [3];
  logic       tx_ready   [3];
  logic       tx_start   [3];
  logic       busy       [3];
  logic       frame_done [3];
  logic [7:0] ch_data    [3];
  logic [7:0] tx_data    [3];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int rel_cyc = 0;
  int start_cnt [3] = '{0, 0, 0};
  int done_cnt  [3] = '{0, 0, 0};
  int hdr_cyc [$];

  // Expected items: bit 8 set marks a frame_done, else a byte.
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];
  logic [8:0] exp_q2 [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    int unsigned uart_cnt = 0;

    sensor_frame_tx #(
      .NUM_CH  (2),
      .DATA_W  (4),
      .INTERVAL((g == 2) ? 100 : 100000),
      .HEADER  (8'hA5),
      .CSUM_EN ((g == 1) ? 0 : 1)
    ) u_dut (
      .clk       (clk),
      .rstn      (rstn[g]),
      .ch_data   (ch_data[g]),
      .trig      (trig[g]),
      .tx_ready  (tx_ready[g]),
      .tx_start  (tx_start[g]),
      .tx_data   (tx_data[g]),
      .busy      (busy[g]),
      .frame_done(frame_done[g])
    );

    // UART stand-in: busy for six cycles after each accepted start.
    always @(posedge clk) begin
      if (tx_start[g]) uart_cnt <= 6;
      else if (uart_cnt != 0) uart_cnt <= uart_cnt - 1;
    end
    assign tx_ready[g] = (uart_cnt == 0);
  end

  task automatic push_item(input int i, input logic [8:0] item);
    case (i)
      0: exp_q0.push_back(item);
      1: exp_q1.push_back(item);
      default: exp_q2.push_back(item);
    endcase
  endtask

  task automatic push_frame(input int i, input logic [7:0] chv, input bit csum);
    logic [7:0] b0, b1, s;
    b0 = {4'h0, chv[3:0]};
    b1 = {4'h0, chv[7:4]};
    s  = 8'hA5 + b0 + b1;
    push_item(i, 9'h0A5);
    push_item(i, {1'b0, b0});
    push_item(i, {1'b0, b1});
    if (csum) push_item(i, {1'b0, s});
    push_item(i, 9'h100);
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic pop_check(input int i, input logic [8:0] act, input string name);
    logic [8:0] e;
    n_vec++;
    if (q_size(i) == 0) begin
      n_err++;
      $display("FAIL %s inst%0d: got %03h, expected nothing", name, i, act);
      return;
    end
    case (i)
      0: e = exp_q0.pop_front();
      1: e = exp_q1.pop_front();
      default: e = exp_q2.pop_front();
    endcase
    if (e !== act) begin
      n_err++;
      $display("FAIL %s inst%0d: got %03h, expected %03h", name, i, act, e);
    end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %02h, required %02h", name, act, req);
    end
  endtask

  // Monitor: every start or done pulse is matched against the scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tx_start[i]) begin
        start_cnt[i]++;
        check($sformatf("ready_at_start%0d", i), {7'h0, tx_ready[i]}, 8'h01);
        pop_check(i, {1'b0, tx_data[i]}, "byte");
        if (i == 2 && tx_data[i] == 8'hA5) hdr_cyc.push_back(cyc - rel_cyc);
      end
      if (frame_done[i]) begin
        done_cnt[i]++;
        pop_check(i, 9'h100, "frame_done");
      end
    end
  end

  task automatic pulse_trig(input int i);
    trig[i] = 1'b1;
    @(negedge clk);
    trig[i] = 1'b0;
  endtask

  task automatic wait_starts(input int i, input int n, input int budget);
    int t = 0;
    while (start_cnt[i] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (start_cnt[i] < n) begin
      n_err++;
      $display("FAIL wait_starts inst%0d: got %0d starts, required %0d", i, start_cnt[i], n);
    end
  endtask

  task automatic wait_dones(input int i, input int n, input int budget);
    int t = 0;
    while (done_cnt[i] < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (done_cnt[i] < n) begin
      n_err++;
      $display("FAIL wait_dones inst%0d: got %0d dones, required %0d", i, done_cnt[i], n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s;
    int base_d;
    int t;
    for (int i = 0; i < 3; i++) begin
      rstn[i] = 1'b0;
      trig[i] = 1'b0;
    end
    ch_data[0] = 8'h3C;
    ch_data[1] = 8'h3C;
    ch_data[2] = 8'h5A;
    for (int k = 0; k < 3; k++) push_frame(2, 8'h5A, 1'b1);
    repeat (3) @(negedge clk);

    // Reset state.
    check("rst_tx_start", {7'h0, tx_start[0]}, 8'h00);
    check("rst_tx_data", tx_data[0], 8'h00);
    check("rst_busy", {7'h0, busy[0]}, 8'h00);
    check("rst_frame_done", {7'h0, frame_done[0]}, 8'h00);

    for (int i = 0; i < 3; i++) rstn[i] = 1'b1;
    rel_cyc = cyc;

    // Basic frame with and without checksum.
    push_frame(0, 8'h3C, 1'b1);
    push_frame(1, 8'h3C, 1'b0);
    trig[0] = 1'b1;
    trig[1] = 1'b1;
    @(negedge clk);
    trig[0] = 1'b0;
    trig[1] = 1'b0;
    wait_dones(0, 1, 300);
    wait_dones(1, 1, 300);
    repeat (20) @(negedge clk);

    // Input change after the header must not reach the frame.
    push_frame(0, 8'h3C, 1'b1);
    base_s = start_cnt[0];
    pulse_trig(0);
    wait_starts(0, base_s + 1, 100);
    ch_data[0] = 8'hFF;
    wait_dones(0, 2, 300);
    ch_data[0] = 8'h3C;
    repeat (10) @(negedge clk);

    // Three requests while busy merge into one follow-on frame.
    push_frame(0, 8'h3C, 1'b1);
    push_frame(0, 8'h21, 1'b1);
    base_s = start_cnt[0];
    pulse_trig(0);
    wait_starts(0, base_s + 1, 100);
    ch_data[0] = 8'h21;
    repeat (3) begin
      repeat (3) @(negedge clk);
      pulse_trig(0);
    end
    t = 0;
    while (!frame_done[0] && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("merge_done_seen", {7'h0, frame_done[0]}, 8'h01);
    @(negedge clk);
    check("merge_load_busy", {7'h0, busy[0]}, 8'h01);
    @(negedge clk);
    check("merge_hdr_start", {7'h0, tx_start[0]}, 8'h01);
    check("merge_hdr_data", tx_data[0], 8'hA5);
    wait_dones(0, 4, 300);
    repeat (30) @(negedge clk);
    ch_data[0] = 8'h3C;

    // Reset while waiting on byte 2 aborts the frame.
    push_item(0, 9'h0A5);
    push_item(0, 9'h00C);
    base_s = start_cnt[0];
    base_d = done_cnt[0];
    pulse_trig(0);
    wait_starts(0, base_s + 2, 100);
    repeat (2) @(negedge clk);
    #2 rstn[0] = 1'b0;
    #1;
    check("abort_tx_start", {7'h0, tx_start[0]}, 8'h00);
    check("abort_busy", {7'h0, busy[0]}, 8'h00);
    check("abort_frame_done", {7'h0, frame_done[0]}, 8'h00);
    check("abort_tx_data", tx_data[0], 8'h00);
    repeat (3) @(negedge clk);
    rstn[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_no_bytes", 8'(start_cnt[0] - base_s), 8'd2);
    push_frame(0, 8'h3C, 1'b1);
    pulse_trig(0);
    wait_dones(0, base_d + 1, 300);

    // Let inst2 complete three auto frames, then stop it.
    while (cyc - rel_cyc < 350) @(negedge clk);
    rstn[2] = 1'b0;
    check("auto_frame_count", 8'(hdr_cyc.size()), 8'd3);
    for (int k = 0; k < hdr_cyc.size() && k < 3; k++) begin
      n_vec++;
      if (hdr_cyc[k] < 100 * (k + 1) - 1 || hdr_cyc[k] > 100 * (k + 1) + 1) begin
        n_err++;
        $display("FAIL auto_start%0d: got cycle %0d, required %0d +/-1", k, hdr_cyc[k],
                 100 * (k + 1));
      end
    end

    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("leftover_inst%0d", i), 8'(q_size(i)), 8'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
